// File: rtl/gp_register_file_pkg.sv
// Shared constants and one-hot select helpers for the MiniSRC general-purpose register file.
package gp_register_file_pkg;

    localparam int NUM_REGS           = 16;
    localparam int REG_IDX_W          = 4;
    localparam int DATA_WIDTH_DEFAULT = 32;

    function automatic logic is_onehot16(input logic [15:0] vec);
        return (vec != 16'h0000) && ((vec & (vec - 16'h0001)) == 16'h0000);
    endfunction

    function automatic logic [REG_IDX_W-1:0] onehot16_to_idx(input logic [15:0] vec);
        logic [REG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (vec[i]) begin
                idx = i[REG_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gp_reg_cell.sv
// Single storage register with load enable and asynchronous active-low clear.
module gp_reg_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/gp_register_file.sv
// Sixteen-entry register file driven by gated one-hot decoder selects, with R0/BAout zeroing
// and a sticky flag for illegal multi-hot selects.
module gp_register_file
    import gp_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter bit R0_BA_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic [15:0]           reg_in_sel,
    input  logic [15:0]           reg_out_sel,
    input  logic                  ba_out,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  sel_err
);

    logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
    logic [NUM_REGS-1:0]   load_en;
    logic                  wr_onehot;
    logic                  wr_multi;
    logic                  rd_onehot;
    logic                  rd_multi;
    logic [REG_IDX_W-1:0]  rd_idx;
    logic                  r0_zero;
    logic                  sel_err_d;
    logic                  sel_err_q;

    // A multi-hot write select must not disturb any register, so load enables are gated as a whole.
    always_comb begin
        wr_onehot = is_onehot16(reg_in_sel);
        wr_multi  = (reg_in_sel != 16'h0000) && !wr_onehot;
        load_en   = wr_onehot ? reg_in_sel : '0;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        gp_reg_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .clk (clk),
            .clr (clr),
            .load(load_en[i]),
            .d   (bus_in),
            .q   (reg_q[i])
        );
    end

    always_comb begin
        rd_onehot = is_onehot16(reg_out_sel);
        rd_multi  = (reg_out_sel != 16'h0000) && !rd_onehot;
        rd_idx    = onehot16_to_idx(reg_out_sel);
        r0_zero   = R0_BA_ZERO && ba_out && (rd_idx == '0);
        bus_out   = '0;
        if (rd_onehot && !r0_zero) begin
            bus_out = reg_q[rd_idx];
        end
    end

    always_comb begin
        sel_err_d = sel_err_q | wr_multi | rd_multi;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_gp_register_file.sv
// Self-checking bench for gp_register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_gp_register_file;

   logic        clk;
   logic        clr;
   logic [31:0] bus_in;
   logic [15:0] reg_in_sel;
   logic [15:0] reg_out_sel;
   logic        ba_out;
   logic [31:0] bus_out;
   logic        sel_err;

   int checkCount;
   int errorCount;

   logic [31:0] modelRegs [16];
   logic        modelErr;

   gp_register_file #(
      .DATA_WIDTH(32),
      .R0_BA_ZERO(1'b1)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .bus_in     (bus_in),
      .reg_in_sel (reg_in_sel),
      .reg_out_sel(reg_out_sel),
      .ba_out     (ba_out),
      .bus_out    (bus_out),
      .sel_err    (sel_err)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h required %h", tag, observed, expected);
      end
   endtask

   // Reference read: only a single selected register is visible, R0 vanishes under BAout
   function automatic logic [31:0] modelRead(input logic [15:0] outSel, input logic ba);
      int k;
      if ($countones(outSel) != 1) return 32'h0;
      k = 0;
      for (int i = 0; i < 16; i++) if (outSel[i]) k = i;
      if (k == 0 && ba) return 32'h0;
      return modelRegs[k];
   endfunction

   // Reference clock-edge behaviour using the inputs currently applied
   task automatic modelEdge();
      int k;
      if (!clr) return;
      if ($countones(reg_in_sel) == 1) begin
         k = 0;
         for (int i = 0; i < 16; i++) if (reg_in_sel[i]) k = i;
         modelRegs[k] = bus_in;
      end
      if ($countones(reg_in_sel) > 1 || $countones(reg_out_sel) > 1) modelErr = 1'b1;
   endtask

   task automatic modelClear();
      for (int i = 0; i < 16; i++) modelRegs[i] = 32'h0;
      modelErr = 1'b0;
   endtask

   // One full cycle: drive, check the combinational read before the edge, check sel_err after it
   task automatic applyStimulus(input logic [15:0] inSel, input logic [15:0] outSel,
                                input logic [31:0] data, input logic ba);
      @(negedge clk);
      reg_in_sel  = inSel;
      reg_out_sel = outSel;
      bus_in      = data;
      ba_out      = ba;
      #1;
      checkOutput("read_pre_edge", bus_out, modelRead(outSel, ba));
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("sel_err", {31'h0, sel_err}, {31'h0, modelErr});
      reg_in_sel  = 16'h0;
      reg_out_sel = 16'h0;
      ba_out      = 1'b0;
   endtask

   task automatic checkAllRegs(input string tag);
      logic [15:0] one;
      one = 16'h0001;
      @(negedge clk);
      reg_in_sel = 16'h0;
      ba_out     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         reg_out_sel = one << i;
         #1;
         checkOutput(tag, bus_out, modelRegs[i]);
      end
      reg_out_sel = 16'h0;
   endtask

   // Assert clr mid-cycle with a legal write pending; everything must read zero and stay zero
   task automatic pulseClear();
      logic [15:0] one;
      one = 16'h0001;
      @(negedge clk);
      reg_in_sel = 16'h0001;
      bus_in     = 32'hFFFFFFFF;
      ba_out     = 1'b0;
      #2;
      clr = 1'b0;
      modelClear();
      for (int i = 0; i < 16; i++) begin
         reg_out_sel = one << i;
         #1;
         checkOutput("clr_read", bus_out, 32'h0);
      end
      @(posedge clk);
      #1;
      reg_out_sel = 16'h0001;
      #1;
      checkOutput("clr_blocks_write", bus_out, 32'h0);
      checkOutput("clr_sel_err", {31'h0, sel_err}, 32'h0);
      @(negedge clk);
      reg_in_sel  = 16'h0;
      reg_out_sel = 16'h0;
      clr         = 1'b1;
   endtask

   function automatic logic [15:0] genSel();
      int r;
      int a;
      int b;
      logic [15:0] one;
      one = 16'h0001;
      r = $urandom_range(0, 99);
      if (r < 15) return 16'h0;
      a = $urandom_range(0, 15);
      if (r < 96) return one << a;
      b = (a + 1 + $urandom_range(0, 14)) % 16;
      return (one << a) | (one << b);
   endfunction

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      clr         = 1'b0;
      bus_in      = 32'h0;
      reg_in_sel  = 16'h0;
      reg_out_sel = 16'h0;
      ba_out      = 1'b0;
      modelClear();

      // Reset state
      repeat (2) @(negedge clk);
      clr         = 1'b1;
      reg_out_sel = 16'h0004;
      #1;
      checkOutput("reset_bus_out", bus_out, 32'h0);
      checkOutput("reset_sel_err", {31'h0, sel_err}, 32'h0);

      // Single write to R5
      applyStimulus(16'h0020, 16'h0000, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      reg_out_sel = 16'h0020;
      #1;
      checkOutput("r5_read", bus_out, 32'hDEADBEEF);
      checkAllRegs("after_r5");

      // R0 storage and BAout zeroing
      applyStimulus(16'h0001, 16'h0000, 32'h12345678, 1'b0);
      applyStimulus(16'h0008, 16'h0000, 32'hA5A5_0003, 1'b0);
      @(negedge clk);
      reg_out_sel = 16'h0001;
      ba_out      = 1'b0;
      #1;
      checkOutput("r0_ba0", bus_out, 32'h12345678);
      ba_out = 1'b1;
      #1;
      checkOutput("r0_ba1", bus_out, 32'h0);
      reg_out_sel = 16'h0008;
      #1;
      checkOutput("r3_ba1", bus_out, 32'hA5A5_0003);
      ba_out = 1'b0;

      // Illegal multi-hot write
      applyStimulus(16'h0180, 16'h0000, 32'hFFFFFFFF, 1'b0);
      checkOutput("multi_wr_err", {31'h0, sel_err}, 32'h1);
      checkAllRegs("after_multi_wr");
      applyStimulus(16'h0002, 16'h0001, 32'h0000_0042, 1'b0);
      checkOutput("err_sticky", {31'h0, sel_err}, 32'h1);
      pulseClear();

      // Multi-hot read drives zero and flags an error
      applyStimulus(16'h0000, 16'h0003, 32'h0, 1'b0);
      checkOutput("multi_rd_err", {31'h0, sel_err}, 32'h1);
      pulseClear();

      // Same-register write and read: no bypass
      applyStimulus(16'h0010, 16'h0000, 32'h1, 1'b0);
      @(negedge clk);
      reg_in_sel  = 16'h0010;
      reg_out_sel = 16'h0010;
      bus_in      = 32'h2;
      #1;
      checkOutput("same_reg_before", bus_out, 32'h1);
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("same_reg_after", bus_out, 32'h2);
      reg_in_sel  = 16'h0;
      reg_out_sel = 16'h0;

      // Fill then clear mid-cycle
      for (int i = 0; i < 16; i++) begin
         applyStimulus(16'h0001 << i, 16'h0000, 32'h100 + i, 1'b0);
      end
      checkAllRegs("filled");
      pulseClear();
      checkAllRegs("after_clear");

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         applyStimulus(genSel(), genSel(), $urandom, 1'($urandom_range(0, 1)));
         if (n % 97 == 96) checkAllRegs("rand_scan");
         if (n % 131 == 130) pulseClear();
      end
      checkAllRegs("final_scan");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/gp_register_file.md
Name: gp_register_file

Overview:
- Sixteen-entry general-purpose register file (R0-R15) for the MiniSRC datapath, sitting directly downstream of the 4-to-16 register-select decoders.
- Consumes the gated one-hot write-select and read-select vectors those decoders produce.
- Writes from the shared bus on the clock edge and drives the selected register back onto the bus.
- Implements the R0/BAout zeroing rule used by base-address arithmetic.

Parameters:
- DATA_WIDTH, 32, width of each register and of both bus ports.
- R0_BA_ZERO, 1, when 1, asserting ba_out while R0 is read-selected drives zero; when 0, ba_out is ignored.

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  asynchronous active-low reset; clears all registers and the error flag
- bus_in  input  DATA_WIDTH  write data from the datapath bus
- reg_in_sel  input  16  one-hot write select (decoder output already ANDed with Rin); bit i selects Ri
- reg_out_sel  input  16  one-hot read select (decoder output already ANDed with Rout); bit i selects Ri
- ba_out  input  1  BAout control; forces R0 reads to zero
- bus_out  output  DATA_WIDTH  selected register contents (combinational read)
- sel_err  output  1  sticky flag: an illegal multi-hot select was seen

Behaviour:
- Reset: clr low clears R0-R15 to 0 and sel_err to 0 immediately, independent of clk.
  - While clr is low, writes are blocked.
  - bus_out follows the read rules over the cleared registers, so it reads 0.
- Write:
  - At the rising clk edge, if reg_in_sel has exactly one bit i set, Ri <= bus_in.
  - If reg_in_sel is all zero, no register changes.
  - If reg_in_sel has two or more bits set, no register changes and sel_err <= 1.
- Read (combinational, zero latency):
  - If reg_out_sel has exactly one bit k set, bus_out = Rk.
  - Exception: k = 0 with ba_out = 1 and R0_BA_ZERO = 1 drives bus_out = 0.
  - If reg_out_sel is all zero, bus_out = 0.
  - If reg_out_sel has two or more bits set, bus_out = 0 and sel_err <= 1 at the next rising edge.
- ba_out has no effect when R0 is not read-selected and never affects writes.
- R0 is a normal storage register: writes to R0 always succeed. Zeroing applies to reads only.
- Write and read of the same register in the same cycle: no bypass.
  - bus_out shows the old value for that cycle.
  - The new value is visible after the edge.
- sel_err is sticky and clears only on clr low. Further errors keep it at 1.
- Simultaneous illegal write select and legal read select: the read proceeds normally, no write occurs, and sel_err sets.
- Reset asserted mid-cycle aborts any pending write. Deassertion takes effect at the next rising edge.
- No X propagation: every select pattern maps to a defined bus_out value.

Decomposition:
- Shared package:
  - NUM_REGS = 16
  - REG_IDX_W = 4
  - DATA_WIDTH default
  - a pure function is_onehot16 returning 1 when exactly one bit is set
  - a pure function onehot16_to_idx returning the 4-bit index
- One natural sub-module, gp_reg_cell: a DATA_WIDTH register with async active-low clr and load enable. The top instantiates it 16 times via generate.
- Select validation, the read mux and sel_err live in the top.

Test Plan:
- clr low, then high; reg_out_sel = 16'h0004 -> bus_out = 0, sel_err = 0.
- bus_in = 32'hDEADBEEF, reg_in_sel = 16'h0020, one edge; reg_out_sel = 16'h0020 -> bus_out = 32'hDEADBEEF; all other registers still 0.
- Write 32'h12345678 to R0; read with reg_out_sel = 16'h0001:
  - ba_out = 0 -> bus_out = 32'h12345678
  - ba_out = 1 -> bus_out = 0
  - read R3 with ba_out = 1 -> R3 contents
- reg_in_sel = 16'h0180, bus_in = 32'hFFFFFFFF, one edge -> R7 and R8 unchanged, sel_err = 1. sel_err stays 1 after legal traffic until clr pulses low, then reads 0.
- Same cycle: R4 = 32'h1, bus_in = 32'h2, reg_in_sel = reg_out_sel = 16'h0010:
  - before the edge, bus_out = 32'h1
  - after the edge, bus_out = 32'h2
- Fill R0-R15 with value 32'h100+i. Pulse clr low between clock edges -> all sixteen reads return 0 immediately and no write occurs on the following edge while clr is low.
